// File: rtl/cpu_pkg.sv
// Shared CPU definitions: MDU opcodes, TNEW width and the E-stage bundle type.
package cpu_pkg;

    localparam int TNEW_W = 2;

    localparam logic [3:0] MDU_NOP   = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MFHI  = 4'd5;
    localparam logic [3:0] MDU_MFLO  = 4'd6;
    localparam logic [3:0] MDU_MTHI  = 4'd7;
    localparam logic [3:0] MDU_MTLO  = 4'd8;

    typedef struct packed {
        logic              valid;
        logic [31:0]       pc;
        logic [31:0]       instr;
        logic [31:0]       rs_val;
        logic [31:0]       rt_val;
        logic [31:0]       imm_ext;
        logic [4:0]        rd_addr;
        logic              reg_we;
        logic [TNEW_W-1:0] tnew;
        logic [3:0]        mdu_op;
        logic              bd;
    } e_bundle_t;

    // Bubble that still carries the stalled instruction's PC and delay-slot flag.
    function automatic e_bundle_t bubble_keep_pc(input logic [31:0] pc, input logic bd);
        e_bundle_t b;
        b    = '0;
        b.pc = pc;
        b.bd = bd;
        return b;
    endfunction

endpackage

// File: rtl/de_pipe_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/de_pipe_reg.sv
// D->E pipeline register with bubble insertion, flush, global hold and a bubble counter.
// Build option DE_PIPE_KEEP_PC_EN: bubbles keep pc/bd of the stalled instruction.
module de_pipe_reg
    import cpu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              hold_i,
    input  logic              valid_d,
    input  logic [31:0]       pc_d,
    input  logic [31:0]       instr_d,
    input  logic [31:0]       rs_val_d,
    input  logic [31:0]       rt_val_d,
    input  logic [31:0]       imm_ext_d,
    input  logic [4:0]        rd_addr_d,
    input  logic              reg_we_d,
    input  logic [TNEW_W-1:0] tnew_d,
    input  logic [3:0]        mdu_op_d,
    input  logic              bd_d,
    output logic              valid_e,
    output logic [31:0]       pc_e,
    output logic [31:0]       instr_e,
    output logic [31:0]       rs_val_e,
    output logic [31:0]       rt_val_e,
    output logic [31:0]       imm_ext_e,
    output logic [4:0]        rd_addr_e,
    output logic              reg_we_e,
    output logic [TNEW_W-1:0] tnew_e,
    output logic [3:0]        mdu_op_e,
    output logic              bd_e,
    output logic [CNT_W-1:0]  bubble_cnt
);

    e_bundle_t bundle_q, bundle_d;
    e_bundle_t load_b, bubble_b;
    logic      bubble_req;

    // An upstream bubble loads normally but must never write back or start the MDU.
    always_comb begin
        load_b.valid   = valid_d;
        load_b.pc      = pc_d;
        load_b.instr   = instr_d;
        load_b.rs_val  = rs_val_d;
        load_b.rt_val  = rt_val_d;
        load_b.imm_ext = imm_ext_d;
        load_b.rd_addr = rd_addr_d;
        load_b.reg_we  = valid_d & reg_we_d;
        load_b.tnew    = tnew_d;
        load_b.mdu_op  = valid_d ? mdu_op_d : MDU_NOP;
        load_b.bd      = bd_d;
    end

`ifdef DE_PIPE_KEEP_PC_EN
    assign bubble_b = bubble_keep_pc(pc_d, bd_d);
`else
    assign bubble_b = '0;
`endif

    assign bubble_req = ~hold_i & (flush_i | stall_i);

    always_comb begin
        bundle_d = load_b;
        if (hold_i) begin
            bundle_d = bundle_q;
        end else if (flush_i || stall_i) begin
            bundle_d = bubble_b;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bundle_q <= '0;
        end else begin
            bundle_q <= bundle_d;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_bubble_cnt (
        .clk  (clk),
        .clr_i(reset),
        .inc_i(bubble_req),
        .cnt_o(bubble_cnt)
    );

    assign valid_e   = bundle_q.valid;
    assign pc_e      = bundle_q.pc;
    assign instr_e   = bundle_q.instr;
    assign rs_val_e  = bundle_q.rs_val;
    assign rt_val_e  = bundle_q.rt_val;
    assign imm_ext_e = bundle_q.imm_ext;
    assign rd_addr_e = bundle_q.rd_addr;
    assign reg_we_e  = bundle_q.reg_we;
    assign tnew_e    = bundle_q.tnew;
    assign mdu_op_e  = bundle_q.mdu_op;
    assign bd_e      = bundle_q.bd;

endmodule

// File: doc/de_pipe_reg.md
# de_pipe_reg

Decode-to-execute pipeline register that feeds the E stage, including the multiply/divide unit's `MDUOp`, `Data1` and `Data2`.
- Captures the decoded instruction bundle from D each cycle.
- Inserts a bubble when the hazard unit stalls D, including on MDU busy/start stalls.
- Squashes its contents on flush and freezes them on a global hold.
- Keeps a saturating bubble counter for performance measurement.

## Interface
Parameters:
- `CNT_W`, default 16: width of the bubble counter.

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `stall_i`  in  1  hazard stall of D (RAW or MDU); E receives a bubble
- `flush_i`  in  1  branch/exception squash; E receives a bubble
- `hold_i`  in  1  global freeze (e.g. memory wait); E keeps its contents
- `valid_d`  in  1  D holds a real instruction
- `pc_d`  in  32  PC of D instruction
- `instr_d`  in  32  raw instruction word
- `rs_val_d`, `rt_val_d`  in  32 each  forwarded operand values
- `imm_ext_d`  in  32  extended immediate
- `rd_addr_d`  in  5  destination register
- `reg_we_d`  in  1  register-file write enable
- `tnew_d`  in  2  cycles until result is available, counted from E
- `mdu_op_d`  in  4  MDU operation code
- `bd_d`  in  1  instruction sits in a branch delay slot
- Registered E-side outputs: `valid_e`, `pc_e`, `instr_e`, `rs_val_e`, `rt_val_e`, `imm_ext_e`, `rd_addr_e`, `reg_we_e`, `tnew_e`, `mdu_op_e`, `bd_e`. Each output has the width of its `_d` input.
- `bubble_cnt`  out  CNT_W  count of bubbles inserted, saturating

## Operation
- Update priority each edge: reset > hold_i > flush_i > stall_i > load.
- **Reset:**
  - All `_e` outputs become 0, so `mdu_op_e` = NOP (0) and `valid_e` = 0.
  - `bubble_cnt` becomes 0.
- **Hold:**
  - Every register keeps its value, including `bubble_cnt`.
  - stall_i and flush_i are ignored in that cycle.
- **Flush or stall (bubble):**
  - `valid_e` = 0, `reg_we_e` = 0, `mdu_op_e` = NOP, `tnew_e` = 0, `rd_addr_e` = 0, `instr_e` = 0.
  - Data fields follow the Configuration rules.
  - `bubble_cnt` increments by 1.
- **Load:**
  - All `_e` outputs take their `_d` inputs.
  - If `valid_d` = 0, the register still loads, but `reg_we_e` and `mdu_op_e` are forced to 0. A bubble from upstream must never start the MDU.
  - A load does not count as a bubble, even when `valid_d` = 0.
- `bubble_cnt` saturates at all-ones; a further bubble leaves it unchanged.
- flush_i and stall_i in the same cycle produce a single bubble and a single increment.

## Timing
- Latency: exactly 1 cycle from D inputs to E outputs.
- No combinational path from any input to any output.
- A stall asserted in cycle n puts NOP on `mdu_op_e` in cycle n+1. This is what lets the MDU drop `start`.
- D itself is held by the hazard unit, not by this block.
- A hold released in cycle n lets the next edge apply normal priority.
- Reset applied while stall_i, flush_i or hold_i is asserted still yields the reset values.

## Configuration
- Macro: `DE_PIPE_KEEP_PC_EN`.
- **Defined:** bubbles load `pc_e` = `pc_d` and `bd_e` = `bd_d`.
  - A bubble in E then still reports the PC and delay-slot flag of the stalled instruction for EPC computation.
  - `rs_val_e`, `rt_val_e` and `imm_ext_e` are set to 0.
- **Undefined:** bubbles set `pc_e` and `bd_e` to 0 as well, i.e. an all-zero bubble apart from `bubble_cnt`.

## Structure
- Shared package `cpu_pkg` holds:
  - the 4-bit MDU opcode constants: NOP 0, MULT 1, MULTU 2, DIV 3, DIVU 4, MFHI 5, MFLO 6, MTHI 7, MTLO 8;
  - the TNEW width;
  - the E-stage bundle struct type.
- One natural sub-module, `sat_counter`: parameterised width, `inc` and `clr` inputs, saturates at max. It implements `bubble_cnt`.
- All other logic is a single registered bundle with a bubble mux.

## Test plan
1. **Reset:** assert reset with all `_d` inputs nonzero -> next cycle all `_e` outputs = 0 and `bubble_cnt` = 0.
2. **Load:** `mdu_op_d` = DIV (3), `rs_val_d` = 0x00000007, `rt_val_d` = 0x00000002, `valid_d` = 1 -> next cycle `mdu_op_e` = 3, operands passed unchanged.
3. **MDU stall:** stall_i = 1 for 3 cycles with `mdu_op_d` = MFLO (6) -> `mdu_op_e` = 0 for 3 cycles and `bubble_cnt` = 3; stall released -> `mdu_op_e` = 6.
4. **Hold vs flush:** hold_i = 1 with flush_i = 1 while E holds MULT -> `mdu_op_e` stays 1 and `bubble_cnt` is unchanged. Next cycle with hold_i = 0 -> bubble.
5. **Macro check:** stall with `pc_d` = 0x00003010, `bd_d` = 1 -> with `DE_PIPE_KEEP_PC_EN`, `pc_e` = 0x00003010 and `bd_e` = 1; without it, both = 0.
6. **Saturation:** `CNT_W` = 4, 17 consecutive stalls -> `bubble_cnt` reaches 15 and stays at 15. `valid_d` = 0 with `reg_we_d` = 1 -> `reg_we_e` = 0.
